instr_slot_arbiter: RTL and testbench

//  Feeds the two dispatcher instruction slots (slot0/slot1, both issued per fabric clk) from a host pair FIFO.

---
 rtl/instr_slot_arbiter_pkg.sv | 51 +++++
 rtl/instr_slot_arbiter_if.sv | 25 ++
 rtl/instr_slot_arbiter_pair_fifo.sv | 44 ++++
 rtl/instr_slot_arbiter.sv | 167 ++++++++++++++++
 tb/tb_instr_slot_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_slot_arbiter_pkg.sv
// Shared opcodes, field offsets, arbiter states and instruction builders for the
// instruction slot arbiter (softMC DDR_INSTR / WAIT encoding).
package instr_slot_arbiter_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned TYPE_OFFSET  = 28;
  localparam logic [3:0]  OP_WAIT      = 4'b0100;
  localparam logic [3:0]  OP_DDR_INSTR = 4'b1000;
  localparam int unsigned CKE_OFFSET   = 27;
  // CS occupies [CS_OFFSET -: cs_w]; RAS/CAS/WE follow directly below it
  localparam int unsigned CS_OFFSET    = 26;
  localparam int unsigned ROW_OFFSET   = 0;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_HOST   = 3'd1,
    ARB_M_PRE  = 3'd2,
    ARB_M_REF  = 3'd3,
    ARB_M_DONE = 3'd4
  } arb_state_e;

  function automatic logic [INSTR_W-1:0] mk_ddr(input int unsigned cs_w, input logic ras,
                                                input logic cas, input logic we, input logic a10);
    logic [INSTR_W-1:0] i;
    i = '0;
    i[TYPE_OFFSET +: 4] = OP_DDR_INSTR;
    i[CKE_OFFSET] = 1'b1;
    i = i | (32'(ras) << (CS_OFFSET - cs_w));
    i = i | (32'(cas) << (CS_OFFSET - cs_w - 1));
    i = i | (32'(we)  << (CS_OFFSET - cs_w - 2));
    i[ROW_OFFSET + 10] = a10;
    return i;
  endfunction

  function automatic logic [INSTR_W-1:0] mk_pre_all(input int unsigned cs_w);
    return mk_ddr(cs_w, 1'b0, 1'b1, 1'b1, 1'b1);
  endfunction

  function automatic logic [INSTR_W-1:0] mk_ref(input int unsigned cs_w);
    return mk_ddr(cs_w, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic [INSTR_W-1:0] mk_wait(input logic [9:0] n);
    logic [INSTR_W-1:0] i;
    i = '0;
    i[TYPE_OFFSET +: 4] = OP_WAIT;
    i[9:0] = n;
    return i;
  endfunction

endpackage

// File: rtl/instr_slot_arbiter_if.sv
// Host pair intake and dual dispatcher slot signals; master = arbiter side.
interface instr_slot_arbiter_if;
  import instr_slot_arbiter_pkg::*;

  logic                 host_valid;
  logic                 host_ready;
  logic [2*INSTR_W-1:0] host_pair;
  logic                 host_last;
  logic                 disp_en0;
  logic [INSTR_W-1:0]   disp_instr0;
  logic                 disp_ack0;
  logic                 disp_en1;
  logic [INSTR_W-1:0]   disp_instr1;
  logic                 disp_ack1;

  modport master (
    input  host_valid, host_pair, host_last, disp_ack0, disp_ack1,
    output host_ready, disp_en0, disp_instr0, disp_en1, disp_instr1
  );

  modport slave (
    output host_valid, host_pair, host_last, disp_ack0, disp_ack1,
    input  host_ready, disp_en0, disp_instr0, disp_en1, disp_instr1
  );
endinterface

// File: rtl/instr_slot_arbiter_pair_fifo.sv
// Host pair FIFO with registered occupancy; push is refused while full.
module pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/instr_slot_arbiter.sv
// Feeds two dispatcher slots from a host pair FIFO and splices PRE-all/REF refresh
// at sequence boundaries. Optional AREF_STARVE_GUARD_EN throttles host intake.
module instr_slot_arbiter
  import instr_slot_arbiter_pkg::*;
#(
  parameter int unsigned PAIR_DEPTH = 4,
  parameter int unsigned T_RP       = 6,
  parameter int unsigned CS_WIDTH   = 1
`ifdef AREF_STARVE_GUARD_EN
  , parameter int unsigned STARVE_MAX = 512
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_slot_arbiter_if.master bus,
  input  logic                 aref_req,
  input  logic [9:0]           aref_trfc,
  output logic                 aref_ack,
  output logic                 busy
);
  localparam logic [INSTR_W-1:0] PRE_ALL = mk_pre_all(CS_WIDTH);
  localparam logic [INSTR_W-1:0] REF_CMD = mk_ref(CS_WIDTH);
  localparam logic [INSTR_W-1:0] WAIT_RP = mk_wait(10'(T_RP));

  arb_state_e          state, state_next;
  logic                cons0, cons1, cons0_next, cons1_next;
  logic                in_seq, in_seq_next;
  logic [1:0]          holdoff, hold_next;
  logic [9:0]          trfc_q;
  logic                load_trfc, pop, full, empty, boundary;
  logic                en0, en1, done0, done1;
  logic [INSTR_W-1:0]  instr0, instr1;
  logic [2*INSTR_W:0]  head;

  pair_fifo #(.DEPTH(PAIR_DEPTH), .WIDTH(2*INSTR_W + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.host_valid & bus.host_ready),
    .wr_data ({bus.host_last, bus.host_pair}),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign boundary        = ~in_seq & ~cons0 & ~cons1;
  assign bus.disp_en0    = en0;
  assign bus.disp_en1    = en1;
  assign bus.disp_instr0 = instr0;
  assign bus.disp_instr1 = instr1;
  assign busy            = ~empty | (state != ARB_IDLE);

  always_comb begin
    state_next  = state;
    cons0_next  = cons0;
    cons1_next  = cons1;
    in_seq_next = in_seq;
    hold_next   = (holdoff != 2'd0) ? holdoff - 2'd1 : 2'd0;
    pop         = 1'b0;
    load_trfc   = 1'b0;
    aref_ack    = 1'b0;
    en0         = 1'b0;
    en1         = 1'b0;
    instr0      = '0;
    instr1      = '0;
    done0       = 1'b0;
    done1       = 1'b0;
    case (state)
      ARB_IDLE, ARB_HOST: begin
        // Refresh takes the slots before a waiting head is ever presented.
        if (aref_req && boundary && holdoff == 2'd0) begin
          state_next = ARB_M_PRE;
        end else begin
          en0 = ~empty & ~cons0;
          en1 = ~empty & ~cons1;
          if (!empty) begin
            instr0 = head[INSTR_W-1:0];
            instr1 = head[2*INSTR_W-1:INSTR_W];
          end
          done0 = cons0 | (bus.disp_ack0 & en0);
          done1 = cons1 | (bus.disp_ack1 & en1);
          if (done0 && done1) begin
            pop         = 1'b1;
            cons0_next  = 1'b0;
            cons1_next  = 1'b0;
            in_seq_next = ~head[2*INSTR_W];
          end else begin
            cons0_next = done0;
            cons1_next = done1;
          end
          if (state == ARB_IDLE) begin
            if (!empty) state_next = ARB_HOST;
          end else if (empty && !cons0 && !cons1) begin
            state_next = ARB_IDLE;
          end
        end
      end
      ARB_M_PRE, ARB_M_REF: begin
        en0    = ~cons0;
        en1    = ~cons1;
        instr0 = (state == ARB_M_PRE) ? PRE_ALL : REF_CMD;
        instr1 = (state == ARB_M_PRE) ? WAIT_RP
                                      : mk_wait((trfc_q == 10'd0) ? 10'd1 : trfc_q);
        done0  = cons0 | bus.disp_ack0;
        done1  = cons1 | bus.disp_ack1;
        if (done0 && done1) begin
          cons0_next = 1'b0;
          cons1_next = 1'b0;
          load_trfc  = (state == ARB_M_PRE);
          state_next = (state == ARB_M_PRE) ? ARB_M_REF : ARB_M_DONE;
        end else begin
          cons0_next = done0;
          cons1_next = done1;
        end
      end
      ARB_M_DONE: begin
        aref_ack   = 1'b1;
        hold_next  = 2'd2;
        state_next = empty ? ARB_IDLE : ARB_HOST;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      cons0   <= 1'b0;
      cons1   <= 1'b0;
      in_seq  <= 1'b0;
      holdoff <= 2'd0;
      trfc_q  <= '0;
    end else begin
      state   <= state_next;
      cons0   <= cons0_next;
      cons1   <= cons1_next;
      in_seq  <= in_seq_next;
      holdoff <= hold_next;
      if (load_trfc) trfc_q <= aref_trfc;
    end
  end

`ifdef AREF_STARVE_GUARD_EN
  logic [9:0] starve_cnt;
  logic       throttle, waiting;

  assign waiting = aref_req & ((state == ARB_IDLE) | (state == ARB_HOST));

  // throttle latches the cycle the counter reaches STARVE_MAX and holds through the refresh
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      throttle   <= 1'b0;
    end else begin
      if (state_next == ARB_M_PRE && state != ARB_M_PRE) starve_cnt <= '0;
      else if (waiting && starve_cnt != 10'(STARVE_MAX)) starve_cnt <= starve_cnt + 10'd1;
      if (state == ARB_M_DONE) throttle <= 1'b0;
      else if (waiting && starve_cnt == 10'(STARVE_MAX - 1)) throttle <= 1'b1;
    end
  end

  assign bus.host_ready = ~full & ~rst & ~throttle;
`else
  assign bus.host_ready = ~full & ~rst;
`endif

endmodule

// File: tb/tb_instr_slot_arbiter.sv
// Scoreboard bench for instr_slot_arbiter: expected slot pairs are queued as stimulus
// is driven and compared when the arbiter presents them.
module tb_instr_slot_arbiter;
  localparam logic [31:0] PRE_ALL = 32'h8980_0400;
  localparam logic [31:0] REF_CMD = 32'h8880_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       aref_req = 1'b0;
  logic [9:0] aref_trfc = 10'd0;
  logic       aref_ack, busy;
  int         errors = 0;
  int         checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got, want;

  instr_slot_arbiter_if bus();

  instr_slot_arbiter #(
    .PAIR_DEPTH(4),
    .T_RP(6),
    .CS_WIDTH(1)
`ifdef AREF_STARVE_GUARD_EN
    , .STARVE_MAX(8)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .aref_req  (aref_req),
    .aref_trfc (aref_trfc),
    .aref_ack  (aref_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pre_pair();
    return {32'h4000_0006, PRE_ALL};
  endfunction

  function automatic logic [63:0] ref_pair(input logic [9:0] trfc);
    return {32'h4000_0000 | {22'd0, (trfc == 10'd0) ? 10'd1 : trfc}, REF_CMD};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input logic a0, input logic a1);
    bus.disp_ack0 = a0;
    bus.disp_ack1 = a1;
  endtask

  task automatic push(input logic [63:0] p, input logic last);
    bus.host_valid = 1'b1;
    bus.host_pair  = p;
    bus.host_last  = last;
    exp_q.push_back(p);
    tick();
    bus.host_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.host_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", bus.host_ready);
    end
    checks++;
    if ({bus.disp_en0, bus.disp_en1, aref_ack, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.disp_en0, bus.disp_en1, aref_ack, busy});
    end
    checks++;
    if ({bus.disp_instr1, bus.disp_instr0} !== 64'd0) begin
      errors++; $display("FAIL reset_instr: got %h expected 0", {bus.disp_instr1, bus.disp_instr0});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.host_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b expected 1", bus.host_ready);
    end
  endtask

  task automatic test_stream();
    set_ack(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.host_valid = 1'b1;
      bus.host_pair  = {32'hA100_0000 + 32'(i), 32'h5100_0000 + 32'(i)};
      bus.host_last  = 1'b1;
      exp_q.push_back(bus.host_pair);
      tick();
      bus.host_valid = 1'b0;
      want = exp_q.pop_front();
      got  = {bus.disp_instr1, bus.disp_instr0};
      checks++;
      if (!(bus.disp_en0 && bus.disp_en1) || got !== want) begin
        errors++; $display("FAIL stream_pair%0d: got en=%b%b %h expected en=11 %h", i, bus.disp_en1, bus.disp_en0, got, want);
      end
    end
    tick();
    checks++;
    if (bus.disp_en0 || bus.disp_en1) begin
      errors++; $display("FAIL stream_drained: got en=%b%b expected 00", bus.disp_en1, bus.disp_en0);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stream_busy: got %b expected 0", busy);
    end
    set_ack(1'b0, 1'b0);
  endtask

  task automatic test_partial_ack();
    push({32'hB0A1_0001, 32'hB0A0_0001}, 1'b1);
    push({32'hB0B1_0002, 32'hB0B0_0002}, 1'b1);
    want = exp_q.pop_front();
    got  = {bus.disp_instr1, bus.disp_instr0};
    checks++;
    if (!(bus.disp_en0 && bus.disp_en1) || got !== want) begin
      errors++; $display("FAIL partial_head: got %h expected %h", got, want);
    end
    set_ack(1'b1, 1'b0);
    tick();
    set_ack(1'b0, 1'b0);
    checks++;
    if (bus.disp_en0 !== 1'b0 || bus.disp_en1 !== 1'b1 || bus.disp_instr1 !== want[63:32]) begin
      errors++; $display("FAIL partial_n1: got en=%b%b i1=%h expected en=10 i1=%h", bus.disp_en1, bus.disp_en0, bus.disp_instr1, want[63:32]);
    end
    tick();
    tick();
    checks++;
    if (bus.disp_en0 !== 1'b0 || bus.disp_en1 !== 1'b1) begin
      errors++; $display("FAIL partial_n3: got en=%b%b expected 10", bus.disp_en1, bus.disp_en0);
    end
    set_ack(1'b0, 1'b1);
    tick();
    set_ack(1'b0, 1'b0);
    want = exp_q.pop_front();
    got  = {bus.disp_instr1, bus.disp_instr0};
    checks++;
    if (!(bus.disp_en0 && bus.disp_en1) || got !== want) begin
      errors++; $display("FAIL partial_next_head: got en=%b%b %h expected en=11 %h", bus.disp_en1, bus.disp_en0, got, want);
    end
    set_ack(1'b1, 1'b1);
    tick();
    set_ack(1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_aref_midseq();
    int ack_cnt;
    ack_cnt = 0;
    push({32'hC001_0001, 32'hC000_0001}, 1'b0);
    push({32'hC001_0002, 32'hC000_0002}, 1'b0);
    push({32'hC001_0003, 32'hC000_0003}, 1'b1);
    want = exp_q.pop_front();
    got  = {bus.disp_instr1, bus.disp_instr0};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL midseq_first: got %h expected %h", got, want);
    end
    set_ack(1'b1, 1'b1);
    tick();
    aref_req  = 1'b1;
    aref_trfc = 10'd88;
    exp_q.push_back(pre_pair());
    exp_q.push_back(ref_pair(10'd88));
    for (int c = 0; c < 20; c++) begin
      if (bus.disp_en0 || bus.disp_en1) begin
        got = {bus.disp_instr1, bus.disp_instr0};
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        checks++;
        if (!(bus.disp_en0 && bus.disp_en1) || got !== want) begin
          errors++; $display("FAIL midseq_order c%0d: got en=%b%b %h expected en=11 %h", c, bus.disp_en1, bus.disp_en0, got, want);
        end
      end
      if (aref_ack) begin
        ack_cnt++;
        aref_req = 1'b0;
      end
      tick();
    end
    set_ack(1'b0, 1'b0);
    checks++;
    if (ack_cnt != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL midseq_ack: got acks=%0d left=%0d expected acks=1 left=0", ack_cnt, exp_q.size());
    end
  endtask

  task automatic test_aref_trfc0();
    int early;
    early = 0;
    aref_trfc = 10'd0;
    aref_req  = 1'b1;
    tick();
    got = {bus.disp_instr1, bus.disp_instr0};
    checks++;
    if (!(bus.disp_en0 && bus.disp_en1) || got !== pre_pair()) begin
      errors++; $display("FAIL trfc0_pre: got en=%b%b %h expected en=11 %h", bus.disp_en1, bus.disp_en0, got, pre_pair());
    end
    set_ack(1'b1, 1'b1);
    tick();
    got = {bus.disp_instr1, bus.disp_instr0};
    checks++;
    if (!(bus.disp_en0 && bus.disp_en1) || got !== ref_pair(10'd0)) begin
      errors++; $display("FAIL trfc0_ref: got %h expected %h", got, ref_pair(10'd0));
    end
    tick();
    set_ack(1'b0, 1'b0);
    checks++;
    if (aref_ack !== 1'b1 || bus.disp_en0 || bus.disp_en1) begin
      errors++; $display("FAIL trfc0_done: got ack=%b en=%b%b expected ack=1 en=00", aref_ack, bus.disp_en1, bus.disp_en0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.disp_en0 || bus.disp_en1 || aref_ack) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL holdoff_quiet: got %0d active cycles expected 0", early);
    end
    tick();
    got = {bus.disp_instr1, bus.disp_instr0};
    checks++;
    if (!(bus.disp_en0 && bus.disp_en1) || got !== pre_pair()) begin
      errors++; $display("FAIL holdoff_retrigger: got en=%b%b %h expected en=11 %h", bus.disp_en1, bus.disp_en0, got, pre_pair());
    end
    set_ack(1'b1, 1'b1);
    tick();
    tick();
    set_ack(1'b0, 1'b0);
    checks++;
    if (aref_ack !== 1'b1) begin
      errors++; $display("FAIL holdoff_done: got ack=%b expected 1", aref_ack);
    end
    aref_req = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_full_and_reset();
    int ack_seen;
    ack_seen = 0;
    for (int i = 0; i < 4; i++) push({32'hD001_0000 + 32'(i), 32'hD000_0000 + 32'(i)}, 1'b1);
    checks++;
    if (bus.host_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b expected 0", bus.host_ready);
    end
    want = exp_q.pop_front();
    got  = {bus.disp_instr1, bus.disp_instr0};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL full_head: got %h expected %h", got, want);
    end
    bus.host_valid = 1'b1;
    bus.host_pair  = 64'hEEEE_EEEE_EEEE_EEEE;
    bus.host_last  = 1'b1;
    set_ack(1'b1, 1'b1);
    tick();
    bus.host_valid = 1'b0;
    set_ack(1'b0, 1'b0);
    checks++;
    if (bus.host_ready !== 1'b1) begin
      errors++; $display("FAIL full_retire_ready: got %b expected 1", bus.host_ready);
    end
    set_ack(1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (bus.disp_en0 || bus.disp_en1) begin
        got = {bus.disp_instr1, bus.disp_instr0};
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL full_drain c%0d: got %h expected %h", c, got, want);
        end
      end
      tick();
    end
    set_ack(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL full_drained: got left=%0d busy=%b expected left=0 busy=0", exp_q.size(), busy);
    end
    aref_trfc = 10'd30;
    aref_req  = 1'b1;
    tick();
    set_ack(1'b1, 1'b1);
    tick();
    set_ack(1'b0, 1'b0);
    got = {bus.disp_instr1, bus.disp_instr0};
    checks++;
    if (got !== ref_pair(10'd30)) begin
      errors++; $display("FAIL rst_pre_ref: got %h expected %h", got, ref_pair(10'd30));
    end
    rst      = 1'b1;
    aref_req = 1'b0;
    tick();
    checks++;
    if ({bus.host_ready, bus.disp_en0, bus.disp_en1, aref_ack, busy} !== 5'b0 ||
        {bus.disp_instr1, bus.disp_instr0} !== 64'd0) begin
      errors++; $display("FAIL rst_mid_ref: got ctl=%b instr=%h expected 0", {bus.host_ready, bus.disp_en0, bus.disp_en1, aref_ack, busy}, {bus.disp_instr1, bus.disp_instr0});
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (aref_ack) ack_seen++;
      tick();
    end
    checks++;
    if (ack_seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_no_ack: got acks=%0d busy=%b expected 0 0", ack_seen, busy);
    end
  endtask

`ifdef AREF_STARVE_GUARD_EN
  task automatic test_starve_guard();
    logic after_ack;
    after_ack = 1'b0;
    push({32'hF001_0001, 32'hF000_0001}, 1'b0);
    push({32'hF001_0002, 32'hF000_0002}, 1'b0);
    push({32'hF001_0003, 32'hF000_0003}, 1'b0);
    push({32'hF001_0004, 32'hF000_0004}, 1'b1);
    want = exp_q.pop_front();
    set_ack(1'b1, 1'b1);
    tick();
    set_ack(1'b0, 1'b0);
    aref_trfc = 10'd20;
    aref_req  = 1'b1;
    exp_q.push_back(pre_pair());
    exp_q.push_back(ref_pair(10'd20));
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        checks++;
        if (bus.host_ready !== 1'b1) begin
          errors++; $display("FAIL starve_ready7: got %b expected 1", bus.host_ready);
        end
      end
    end
    checks++;
    if (bus.host_ready !== 1'b0) begin
      errors++; $display("FAIL starve_ready8: got %b expected 0", bus.host_ready);
    end
    set_ack(1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (after_ack) begin
        after_ack = 1'b0;
        checks++;
        if (bus.host_ready !== 1'b1) begin
          errors++; $display("FAIL starve_ready_back: got %b expected 1", bus.host_ready);
        end
      end
      if (bus.disp_en0 || bus.disp_en1) begin
        got = {bus.disp_instr1, bus.disp_instr0};
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL starve_drain c%0d: got %h expected %h", c, got, want);
        end
      end
      if (aref_ack) begin
        checks++;
        if (bus.host_ready !== 1'b0) begin
          errors++; $display("FAIL starve_ready_done: got %b expected 0", bus.host_ready);
        end
        aref_req  = 1'b0;
        after_ack = 1'b1;
      end
      tick();
    end
    set_ack(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL starve_left: got %0d expected 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    bus.host_valid = 1'b0;
    bus.host_pair  = '0;
    bus.host_last  = 1'b0;
    set_ack(1'b0, 1'b0);
    test_reset();
    test_stream();
    test_partial_ack();
    test_aref_midseq();
    test_aref_trfc0();
    test_full_and_reset();
`ifdef AREF_STARVE_GUARD_EN
    test_starve_guard();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
